// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, start/busy/done handshake
//
// Computes d = (a - b - bin) mod 2^WIDTH one bit per clock using a single
// full-subtractor cell and a registered borrow.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  operation request, sampled only in IDLE
//   a, b   minuend / subtrahend, captured on the accepted start edge
//   bin    borrow-in, captured on the accepted start edge
//   busy   high while bits are being processed (RUN)
//   done   one-cycle pulse when d, v and ovf are freshly updated
//   d      difference
//   v      final borrow (unsigned a < b + bin)
//   ovf    two's-complement overflow of the subtraction

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             v,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  // Full-subtractor cell on the current LSBs.
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    diff_bit    = sa[0] ^ sb[0] ^ br;
    borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sr_next     = {diff_bit, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      v     <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          br  <= borrow_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // sr_next already holds the MSB processed on this edge.
            d     <= sr_next;
            v     <= borrow_next;
            ovf   <= (a_msb != b_msb) && (sr_next[WIDTH-1] != a_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH 8, 16, 2)

module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        st8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, v8, ovf8;
  logic [7:0]  d8;
  // WIDTH=16 instance
  logic        st16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, v16, ovf16;
  logic [15:0] d16;
  // WIDTH=2 instance
  logic        st2 = 1'b0, bin2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, v2, ovf2;
  logic [1:0]  d2;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .v(v8), .ovf(ovf8)
  );
  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .d(d16), .v(v16), .ovf(ovf16)
  );
  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .d(d2), .v(v2), .ovf(ovf2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs of the selected instance (w = 8, 16 or 2).
  task automatic drive(input int w, input logic st, input logic [63:0] av,
                       input logic [63:0] bv, input logic bi);
    case (w)
      16: begin st16 = st; a16 = av[15:0]; b16 = bv[15:0]; bin16 = bi; end
      2:  begin st2  = st; a2  = av[1:0];  b2  = bv[1:0];  bin2  = bi; end
      default: begin st8 = st; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; end
    endcase
  endtask

  task automatic sample(input int w, output logic bsy, output logic dn,
                        output logic [63:0] dd, output logic vv, output logic ov);
    case (w)
      16: begin bsy = busy16; dn = done16; dd = 64'(d16); vv = v16; ov = ovf16; end
      2:  begin bsy = busy2;  dn = done2;  dd = 64'(d2);  vv = v2;  ov = ovf2;  end
      default: begin bsy = busy8; dn = done8; dd = 64'(d8); vv = v8; ov = ovf8; end
    endcase
  endtask

  // Called at a negedge: start is sampled at the next posedge (E0); returns
  // at the negedge right after E0.
  task automatic start_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                          input logic bi);
    drive(w, 1'b1, av, bv, bi);
    @(negedge clk);
    drive(w, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 64'h1234_5678_9ABC_DEF0, ~bi);
  endtask

  // Called right after E0; waits for done, checks latency, busy span and result,
  // then steps one more cycle and checks return to idle.
  task automatic wait_check(input string tag, input int w, input logic [63:0] ed,
                            input logic ev, input logic eo);
    logic bsy, dn, vv, ov;
    logic [63:0] dd;
    int cyc = 0, busy_cnt = 0, both = 0;
    sample(w, bsy, dn, dd, vv, ov);
    while (!dn && cyc < 200) begin
      if (bsy) busy_cnt++;
      @(negedge clk);
      cyc++;
      sample(w, bsy, dn, dd, vv, ov);
      if (bsy && dn) both++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(w));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(w));
    check({tag, " busy_with_done"}, 64'(both), 64'd0);
    check({tag, " d"}, dd, ed);
    check({tag, " v"}, 64'(vv), 64'(ev));
    check({tag, " ovf"}, 64'(ov), 64'(eo));
    @(negedge clk);
    sample(w, bsy, dn, dd, vv, ov);
    check({tag, " done_drop"}, 64'(dn), 64'd0);
    check({tag, " idle_busy"}, 64'(bsy), 64'd0);
  endtask

  task automatic run(input string tag, input int w, input logic [63:0] av,
                     input logic [63:0] bv, input logic bi, input logic [63:0] ed,
                     input logic ev, input logic eo);
    start_op(w, av, bv, bi);
    wait_check(tag, w, ed, ev, eo);
  endtask

  initial begin
    logic bsy, dn, vv, ov;
    logic [63:0] dd;
    int pulses;

    repeat (2) @(negedge clk);
    sample(8, bsy, dn, dd, vv, ov);
    check("reset busy", 64'(bsy), 64'd0);
    check("reset done", 64'(dn), 64'd0);
    check("reset d", dd, 64'd0);
    check("reset v", 64'(vv), 64'd0);
    check("reset ovf", 64'(ov), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("5-3",     8, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, 1'b0);
    run("3-5",     8, 64'h03, 64'h05, 1'b0, 64'hFE, 1'b1, 1'b0);
    run("80-01",   8, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1);
    run("7F-FF",   8, 64'h7F, 64'hFF, 1'b0, 64'h80, 1'b1, 1'b1);
    run("0-0-1",   8, 64'h00, 64'h00, 1'b1, 64'hFF, 1'b1, 1'b0);
    run("0-0",     8, 64'h00, 64'h00, 1'b0, 64'h00, 1'b0, 1'b0);
    run("A5-A5",   8, 64'hA5, 64'hA5, 1'b0, 64'h00, 1'b0, 1'b0);
    run("0-1",     8, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1, 1'b0);

    // start during RUN and during DONE must be ignored
    start_op(8, 64'h40, 64'h10, 1'b0);
    pulses = 0;
    repeat (3) @(negedge clk);
    drive(8, 1'b1, 64'h01, 64'h02, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 64'h00, 64'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample(8, bsy, dn, dd, vv, ov);
      if (dn) begin
        pulses++;
        check("ign d", dd, 64'h30);
        check("ign v", 64'(vv), 64'd0);
        // pulse start while in DONE; sampled on the edge leaving DONE
        drive(8, 1'b1, 64'h09, 64'h0A, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 64'h00, 64'h00, 1'b0);
        sample(8, bsy, dn, dd, vv, ov);
        check("ign done_start busy", 64'(bsy), 64'd0);
        if (dn) pulses++;
      end
      if (bsy && i > 12) pulses = pulses + 100;
      @(negedge clk);
    end
    check("ign pulses", 64'(pulses), 64'd1);
    run("after_ign", 8, 64'h22, 64'h11, 1'b0, 64'h11, 1'b0, 1'b0);

    // back-to-back: accept start on the first IDLE edge after DONE
    run("b2b_a", 8, 64'h10, 64'h01, 1'b0, 64'h0F, 1'b0, 1'b0);
    run("b2b_b", 8, 64'h01, 64'h10, 1'b0, 64'hF1, 1'b1, 1'b0);

    // reset during cycle 4 of RUN
    start_op(8, 64'h55, 64'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(8, bsy, dn, dd, vv, ov);
    check("abort busy", 64'(bsy), 64'd0);
    check("abort done", 64'(dn), 64'd0);
    check("abort d", dd, 64'd0);
    check("abort v", 64'(vv), 64'd0);
    check("abort ovf", 64'(ov), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(8, bsy, dn, dd, vv, ov);
      if (dn || bsy) pulses++;
    end
    check("abort no_done", 64'(pulses), 64'd0);
    run("post_abort", 8, 64'h55, 64'h11, 1'b0, 64'h44, 1'b0, 1'b0);

    run("w16", 16, 64'h0000, 64'hFFFF, 1'b0, 64'h0001, 1'b1, 1'b0);
    run("w16b", 16, 64'h8000, 64'h0001, 1'b1, 64'h7FFE, 1'b0, 1'b1);
    run("w2", 2, 64'h2, 64'h1, 1'b0, 64'h1, 1'b0, 1'b1);
    run("w2b", 2, 64'h0, 64'h3, 1'b1, 64'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
